smbs_serializer: RTL and testbench
==================================

# smbs_serializer

Transmit-side counterpart of the serial message broadcaster: builds and shifts out, one bit per clock, the frame that the broadcaster's controller parses. A frame is a start bit, 4-bit port, 2-bit line, 6-bit chunk size N, then N payload bits. The block sits between a host that supplies the header in parallel and the payload one bit at a time, and the single serial line (`serOut`) that feeds `smbs`/`Controller`.

## Interface
Parameters:
- `PORT_W`, 4, port address field width
- `LINE_W`, 2, line select field width
- `SIZE_W`, 6, chunk-size field width; max payload 2^SIZE_W−1 bits

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start_req`  in  1  request a frame; sampled only when `busy`=0
- `port_in`  in  PORT_W  destination port, latched with `start_req`
- `line_in`  in  LINE_W  destination line, latched with `start_req`
- `size_in`  in  SIZE_W  payload length N, latched with `start_req`
- `bit_in`  in  1  next payload bit
- `bit_valid`  in  1  `bit_in` is valid
- `bit_ready`  out  1  block consumes `bit_in` at this edge if valid
- `serOut`  out  1  serial line, registered; idles at 1
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after last frame bit
- `underflow`  out  1  sticky: a payload bit was missing in this frame

## Operation
- States: IDLE, START, HDR, DATA.
- IDLE: `serOut`=1, `busy`=0. `start_req`=1 at an edge latches port/line/size, enters START, clears `underflow`.
- START: `serOut`=0 for one cycle → HDR.
- HDR: 12 cycles, port MSB-first, then line MSB-first, then size MSB-first (12-bit PISO). After last size bit → DATA if N>0, else IDLE.
- DATA: N cycles, one payload bit per cycle, bit count modulo-free (counter width SIZE_W, counts up to N−1). Then → IDLE.
- Payload handshake: `bit_ready` is combinational, high in the last HDR cycle and every DATA cycle except the last (exactly N cycles). On an edge with `bit_ready`: `serOut`<=`bit_in` if `bit_valid`; else `serOut`<=0 and `underflow`<=1. The line never stalls; the receiver counts cycles.
- `start_req` while `busy`=1: ignored, no latching.
- Latched header is stable for the whole frame; changes on `port_in/line_in/size_in` during a frame have no effect.

## Timing
- `start_req` sampled high at edge ending cycle t (IDLE): cycle t+1 `serOut`=0, `busy`=1.
- t+2..t+5 port[3..0]; t+6..t+7 line[1..0]; t+8..t+13 size[5..0].
- Payload bit k (k=0..N−1) consumed at edge ending cycle t+13+k, on `serOut` during t+14+k.
- Cycle t+14+N: `serOut`=1, `busy`=0, `done`=1 (one cycle). Frame length 13+N cycles on the line.
- Back-to-back: `start_req` accepted in the `done` cycle → next start bit at t+15+N (one idle-high cycle between frames, always).
- N=0: `done` at t+14, `bit_ready` never asserted.
- Reset (async, any time incl. mid-frame): `serOut`=1, `busy`=0, `done`=0, `underflow`=0, `bit_ready`=0, state IDLE, counters 0; the partial frame is abandoned.

## Structure
- Shared package `smbs_pkg`: PORT_W, LINE_W, SIZE_W, HDR_W (=PORT_W+LINE_W+SIZE_W), state enum type.
- Sub-module `hdr_piso`: HDR_W-bit parallel-load, MSB-first shift register with load/shift enables; FSM, bit counter and payload path stay in the top.

## Test plan
- port=1001, line=11, N=5, payload 10101 with `bit_valid` always 1 → `serOut` from t+1: 0,1001,11,000101,10101, then 1; `done` at t+19; `underflow`=0.
- N=0, port=0001, line=10 → 0,0001,10,000000, `done` at t+14, `bit_ready` never high.
- N=3, `bit_valid` low for bit 1, payload 1x1 → line bits 1,0,1; `underflow`=1 held until next `start_req`.
- `start_req` pulsed at t+5 mid-frame with different header → ignored; frame unchanged.
- `rst` at t+9 → `serOut`=1 and `busy`=0 before next edge; new `start_req` afterwards gives a clean frame.
- Two back-to-back frames, N=63 then N=1, `start_req` held high → exactly one idle-high cycle between frames, 63 `bit_ready` cycles in first, correct `done` pulses.

Source files
------------

// File: rtl/smbs_pkg.sv
// Shared field widths and FSM state type for the smbs frame serializer.
package smbs_pkg;

  localparam int PORT_W = 4;
  localparam int LINE_W = 2;
  localparam int SIZE_W = 6;
  localparam int HDR_W  = PORT_W + LINE_W + SIZE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_HDR,
    ST_DATA
  } state_e;

endpackage

// File: rtl/smbs_serializer_hdr_piso.sv
// Parallel-load, MSB-first shift register holding the frame header.
module hdr_piso #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[W-2:0], 1'b0};
    end
  end

  // NOTE: a plain register, not a memory, so it takes the async reset like any other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[W-1];

endmodule

// File: rtl/smbs_serializer.sv
// Frame serializer: start bit, port/line/size header, then N host-supplied payload bits.
module smbs_serializer
  import smbs_pkg::*;
#(
  parameter int PORT_W = smbs_pkg::PORT_W,
  parameter int LINE_W = smbs_pkg::LINE_W,
  parameter int SIZE_W = smbs_pkg::SIZE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_req,
  input  logic [PORT_W-1:0] port_in,
  input  logic [LINE_W-1:0] line_in,
  input  logic [SIZE_W-1:0] size_in,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic              serOut,
  output logic              busy,
  output logic              done,
  output logic              underflow
);

  localparam int LOCAL_HDR_W = PORT_W + LINE_W + SIZE_W;
  localparam logic [SIZE_W-1:0] HDR_LAST = SIZE_W'(LOCAL_HDR_W - 1);

  state_e            state_q, state_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic              ser_q, ser_d;
  logic              done_q, done_d;
  logic              unf_q, unf_d;
  logic              piso_load, piso_shift, piso_msb;

  hdr_piso #(.W(LOCAL_HDR_W)) u_hdr_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .data_i  ({port_in, line_in, size_in}),
    .msb_o   (piso_msb)
  );

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    ser_d      = ser_q;
    done_d     = 1'b0;
    unf_d      = unf_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    bit_ready  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ser_d = 1'b1;
        if (start_req) begin
          state_d   = ST_START;
          size_d    = size_in;
          cnt_d     = '0;
          unf_d     = 1'b0;
          piso_load = 1'b1;
          ser_d     = 1'b0;
        end
      end
      ST_START: begin
        ser_d      = piso_msb;
        piso_shift = 1'b1;
        cnt_d      = '0;
        state_d    = ST_HDR;
      end
      ST_HDR: begin
        if (cnt_q != HDR_LAST) begin
          ser_d      = piso_msb;
          piso_shift = 1'b1;
          cnt_d      = cnt_q + SIZE_W'(1);
        end else if (size_q == '0) begin
          ser_d   = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          // Payload bit 0 is taken on the last header edge so it lands right after size[0].
          bit_ready = 1'b1;
          ser_d     = bit_valid & bit_in;
          unf_d     = unf_q | ~bit_valid;
          cnt_d     = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == size_q - SIZE_W'(1)) begin
          ser_d   = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          bit_ready = 1'b1;
          ser_d     = bit_valid & bit_in;
          unf_d     = unf_q | ~bit_valid;
          cnt_d     = cnt_q + SIZE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
      unf_q   <= unf_d;
    end
  end

  assign serOut    = ser_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_smbs_serializer.sv
// Self-checking bench for smbs_serializer: table vectors, hand-written corners, random frames.
module tb_smbs_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_req;
  logic [3:0] port_in;
  logic [1:0] line_in;
  logic [5:0] size_in;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       serOut;
  logic       busy;
  logic       done;
  logic       underflow;

  int n_pass  = 0;
  int n_total = 0;

  smbs_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .start_req (start_req),
    .port_in   (port_in),
    .line_in   (line_in),
    .size_in   (size_in),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .serOut    (serOut),
    .busy      (busy),
    .done      (done),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  port;
    logic [1:0]  line;
    logic [5:0]  size;
    logic [62:0] pay;
    logic [62:0] vld;
    logic        chain;
    logic        exp_unf;
    int          exp_done;
  } vec_t;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Entered at the falling edge of an idle cycle t; returns at the falling edge of the done cycle.
  task automatic run_frame(input string nm, input logic [3:0] p, input logic [1:0] l,
                           input logic [5:0] n, input logic [62:0] pay, input logic [62:0] vld,
                           input logic hold_req, input logic exp_unf, input int exp_done);
    logic [11:0]  hdr;
    logic [127:0] gs, es, gb, eb, gr, er, gd, ed;
    logic         unf_first, unf_last;
    int           last;
    hdr  = {p, l, n};
    last = 14 + int'(n);
    gs = '0; es = '0; gb = '0; eb = '0; gr = '0; er = '0; gd = '0; ed = '0;
    // Reference frame built straight from the line timing: start, header MSB-first, payload.
    for (int c = 1; c < last; c++) begin
      if (c == 1)       es[c] = 1'b0;
      else if (c <= 13) es[c] = hdr[13-c];
      else              es[c] = vld[c-14] & pay[c-14];
      eb[c] = 1'b1;
      er[c] = (c >= 13) && (c - 13 < int'(n));
    end
    es[last]     = 1'b1;
    ed[exp_done] = 1'b1;

    start_req = 1'b1;
    port_in   = p;
    line_in   = l;
    size_in   = n;
    @(posedge clk);
    @(negedge clk);
    start_req = hold_req;
    unf_first = 1'b0;
    unf_last  = 1'b0;
    for (int c = 1; c <= last; c++) begin
      gs[c] = serOut;
      gb[c] = busy;
      gr[c] = bit_ready;
      gd[c] = done;
      if (c == 1)    unf_first = underflow;
      if (c == last) unf_last  = underflow;
      port_in = 4'($urandom);
      line_in = 2'($urandom);
      size_in = 6'($urandom);
      if (c >= 13 && c - 13 < int'(n)) begin
        bit_valid = vld[c-13];
        bit_in    = pay[c-13];
      end else begin
        bit_valid = 1'($urandom);
        bit_in    = 1'($urandom);
      end
      if (c < last) @(negedge clk);
    end
    check({nm, "_serout"},   gs, es);
    check({nm, "_busy"},     gb, eb);
    check({nm, "_bitready"}, gr, er);
    check({nm, "_done"},     gd, ed);
    check({nm, "_unf_clr"},  128'(unf_first), 128'(0));
    check({nm, "_unf_end"},  128'(unf_last),  128'(exp_unf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[5];
    logic [63:0] r64;
    logic [62:0] pay, vld;
    logic [5:0]  n;
    logic        unf, chain;

    tbl[0] = '{"basic",  4'b1001, 2'b11, 6'd5,  63'b10101, 63'b11111, 1'b0, 1'b0, 19};
    tbl[1] = '{"n0",     4'b0001, 2'b10, 6'd0,  63'd0,     63'd0,     1'b0, 1'b0, 14};
    tbl[2] = '{"unfl",   4'b0110, 2'b01, 6'd3,  63'b111,   63'b101,   1'b0, 1'b1, 17};
    tbl[3] = '{"n63",    4'b1110, 2'b00, 6'd63, 63'h1B3C_4D5E_6F70_8192, {63{1'b1}}, 1'b1, 1'b0, 77};
    tbl[4] = '{"n1_b2b", 4'b0101, 2'b11, 6'd1,  63'd0,     63'd1,     1'b0, 1'b0, 15};

    rst       = 1'b1;
    start_req = 1'b0;
    port_in   = '0;
    line_in   = '0;
    size_in   = '0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    @(negedge clk);
    check("reset_state", 128'({serOut, busy, done, underflow, bit_ready}), 128'(5'b10000));
    rst = 1'b0;
    @(negedge clk);
    check("idle_state", 128'({serOut, busy, done, bit_ready}), 128'(4'b1000));

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].name, tbl[i].port, tbl[i].line, tbl[i].size, tbl[i].pay, tbl[i].vld,
                tbl[i].chain, tbl[i].exp_unf, tbl[i].exp_done);
      if (!tbl[i].chain) begin
        start_req = 1'b0;
        @(negedge clk);
        check({tbl[i].name, "_after"}, 128'({serOut, busy, done, underflow}),
              128'({1'b1, 1'b0, 1'b0, tbl[i].exp_unf}));
        @(negedge clk);
      end
    end

    // Mid-frame reset: size=000011 puts a 0 on the line during t+9, so the forced 1 is visible.
    start_req = 1'b1;
    port_in   = 4'b1010;
    line_in   = 2'b01;
    size_in   = 6'b000011;
    @(posedge clk);
    @(negedge clk);
    start_req = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_line", 128'({serOut, busy}), 128'(2'b01));
    rst = 1'b1;
    #1;
    check("async_reset", 128'({serOut, busy, done, underflow, bit_ready}), 128'(5'b10000));
    @(negedge clk);
    rst = 1'b0;
    run_frame("after_rst", 4'b0011, 2'b10, 6'd4, 63'b0110, 63'b1111, 1'b0, 1'b0, 18);
    start_req = 1'b0;
    @(negedge clk);

    for (int f = 0; f < 24; f++) begin
      r64 = {$urandom, $urandom};
      pay = r64[62:0];
      n   = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
      vld = '0;
      unf = 1'b0;
      for (int k = 0; k < 63; k++) vld[k] = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < int'(n); k++) unf = unf | ~vld[k];
      chain = ($urandom_range(0, 3) == 0);
      run_frame($sformatf("rnd%0d", f), 4'($urandom), 2'($urandom), n, pay, vld,
                chain, unf, 14 + int'(n));
      if (!chain) begin
        start_req = 1'b0;
        @(negedge clk);
        check($sformatf("rnd%0d_after", f), 128'({serOut, busy, done, underflow}),
              128'({1'b1, 1'b0, 1'b0, unf}));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    start_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
